// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control code table, FSM encoding and width defaults.
// Used by the ALU controller and alu_exec_unit (optional ALU_EXEC_OVERFLOW_EN).
package alu_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SLLV = 4'b1000;
    localparam logic [3:0] ALU_ORI  = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1100;
    localparam logic [3:0] ALU_BEQ  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between EX control and alu_exec_unit.
// overflow_o exists only when ALU_EXEC_OVERFLOW_EN is defined.
interface alu_exec_unit_if;
    import alu_ctrl_pkg::*;

    logic               in_valid_i;
    logic               in_ready_o;
    logic [3:0]         alu_ctrl_i;
    logic [DATA_W-1:0]  src1_i;
    logic [DATA_W-1:0]  src2_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  result_o;
    logic               zero_o;
    logic               illegal_o;
`ifdef ALU_EXEC_OVERFLOW_EN
    logic               overflow_o;
`endif

    modport master (
        output in_valid_i, alu_ctrl_i, src1_i, src2_i, shamt_i,
        output out_ready_i,
`ifdef ALU_EXEC_OVERFLOW_EN
        input  overflow_o,
`endif
        input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  in_valid_i, alu_ctrl_i, src1_i, src2_i, shamt_i,
        input  out_ready_i,
`ifdef ALU_EXEC_OVERFLOW_EN
        output overflow_o,
`endif
        output in_ready_o, out_valid_o, result_o, zero_o, illegal_o
    );

endinterface

// File: rtl/alu_shifter.sv
// Iterative left shifter: one bit per cycle, zero fill.
// done flags the cycle whose edge produces the final value on result.
module alu_shifter
    import alu_ctrl_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int CW = SHAMT_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic [CW-1:0] count,
    output logic [W-1:0]  result,
    output logic          done
);

    logic [W-1:0]  val_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            val_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            val_q <= load_val;
            cnt_q <= count;
        end else if (cnt_q != '0) begin
            val_q <= {val_q[W-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign result = {val_q[W-2:0], 1'b0};
    assign done   = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU for EX: single-cycle ops plus iterative sll/sllv.
// Define ALU_EXEC_OVERFLOW_EN to add the registered overflow_o flag.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = alu_ctrl_pkg::DATA_W,
    parameter int SHAMT_W = alu_ctrl_pkg::SHAMT_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_exec_unit_if.slave bus
);

    localparam int MSB = DATA_W - 1;

    alu_state_e state_q, state_d;

    logic [DATA_W-1:0]  a, b, sum, diff, alu_res, sh_res, res_q;
    logic [SHAMT_W-1:0] amt;
    logic               sub_ovf, alu_ill, is_shift;
    logic               in_ready, accept, sh_load, sh_done;
    logic               zero_q, ill_q;

    assign a    = bus.src1_i;
    assign b    = bus.src2_i;
    assign sum  = a + b;
    assign diff = a - b;

    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        amt      = bus.shamt_i;
        unique case (bus.alu_ctrl_i)
            ALU_ADD:         alu_res = sum;
            ALU_SUB:         alu_res = diff;
            ALU_AND:         alu_res = a & b;
            ALU_OR, ALU_ORI: alu_res = a | b;
            // sign taken from the difference, corrected for overflow
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, diff[MSB] ^ sub_ovf};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, a < b};
            ALU_SLL: begin
                is_shift = 1'b1;
                alu_res  = b;
            end
            ALU_SLLV: begin
                is_shift = 1'b1;
                alu_res  = b;
                amt      = a[SHAMT_W-1:0];
            end
            ALU_LUI:  alu_res = {b[15:0], 16'h0000};
            ALU_BEQ:  alu_res = diff;
            default:  alu_ill = 1'b1;
        endcase
    end

    assign in_ready = rst_i && (state_q == S_IDLE);
    assign accept   = bus.in_valid_i && in_ready;

    always_comb begin
        state_d = state_q;
        sh_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && amt != '0) begin
                        sh_load = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: if (sh_done) state_d = S_DONE;
            S_DONE:  if (bus.out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !sh_load) begin
                res_q  <= alu_res;
                zero_q <= (alu_res == '0);
                ill_q  <= alu_ill;
            end else if (state_q == S_SHIFT && sh_done) begin
                res_q  <= sh_res;
                zero_q <= (sh_res == '0);
                ill_q  <= 1'b0;
            end
        end
    end

    alu_shifter #(
        .W  (DATA_W),
        .CW (SHAMT_W)
    ) u_shifter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (sh_load),
        .load_val (b),
        .count    (amt),
        .result   (sh_res),
        .done     (sh_done)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = rst_i && (state_q == S_DONE);
    assign bus.result_o    = rst_i ? res_q : '0;
    assign bus.zero_o      = rst_i && zero_q;
    assign bus.illegal_o   = rst_i && ill_q;

`ifdef ALU_EXEC_OVERFLOW_EN
    logic add_ovf, alu_ovf, ovf_q;

    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign alu_ovf = (bus.alu_ctrl_i == ALU_ADD && add_ovf) ||
                     (bus.alu_ctrl_i == ALU_SUB && sub_ovf);

    // shifts never overflow, so the accept-time value is final
    always_ff @(posedge clk_i) begin
        if (!rst_i)      ovf_q <= 1'b0;
        else if (accept) ovf_q <= alu_ovf;
    end

    assign bus.overflow_o = rst_i && ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit.
// Overflow checks are compiled in when ALU_EXEC_OVERFLOW_EN is defined.
module tb_alu_exec_unit;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic        ovf;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alu_exec_unit_if bus();

    alu_exec_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] res, input logic z,
                         input logic il, input logic ov, input int lat,
                         input string tag);
        exp_t e;
        int   w = 0;
        while (bus.in_ready_o !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_rdy"}, bus.in_ready_o, 1);
        bus.alu_ctrl_i = code;
        bus.src1_i     = a;
        bus.src2_i     = b;
        bus.shamt_i    = sh;
        bus.in_valid_i = 1'b1;
        e.res = res; e.zero = z; e.ill = il; e.ovf = ov;
        e.lat = lat; e.tag = tag;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.alu_ctrl_i = 4'($urandom);
        bus.src1_i     = $urandom;
        bus.src2_i     = $urandom;
        bus.shamt_i    = 5'($urandom);
    endtask

    task automatic collect();
        exp_t e;
        int   cyc = 0;
        while (bus.out_valid_o !== 1'b1 && cyc < 64) begin
            chk("busy_rdy", bus.in_ready_o, 0);
            @(posedge clk); #1;
            cyc++;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_lat"}, cyc + 1, e.lat);
            chk({e.tag, "_res"}, bus.result_o, e.res);
            chk({e.tag, "_zero"}, bus.zero_o, e.zero);
            chk({e.tag, "_ill"}, bus.illegal_o, e.ill);
`ifdef ALU_EXEC_OVERFLOW_EN
            chk({e.tag, "_ovf"}, bus.overflow_o, e.ovf);
`endif
            chk({e.tag, "_done_rdy"}, bus.in_ready_o, 0);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        chk("idle_valid", bus.out_valid_o, 0);
        chk("idle_rdy", bus.in_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.alu_ctrl_i  = '0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.shamt_i     = '0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", bus.in_ready_o, 0);
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_res", bus.result_o, 0);
        chk("rst_zero", bus.zero_o, 0);
        chk("rst_ill", bus.illegal_o, 0);
`ifdef ALU_EXEC_OVERFLOW_EN
        chk("rst_ovf", bus.overflow_o, 0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy", bus.in_ready_o, 1);
        chk("post_rst_valid", bus.out_valid_o, 0);

        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 0, 0, 1, 1, "add_ovf");
        collect();
        issue(ALU_ADD, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0, 0, 1, "add_zero");
        collect();
        issue(ALU_SUB, 32'h3, 32'h5, 5'd0, 32'hFFFF_FFFE, 0, 0, 0, 1, "sub_neg");
        collect();
        issue(ALU_SUB, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 0, 0, 1, 1, "sub_ovf");
        collect();
        issue(ALU_BEQ, 32'h5, 32'h5, 5'd0, 32'h0, 1, 0, 0, 1, "beq_eq");
        collect();
        issue(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F, 0, 0, 0, 1, "and");
        collect();
        issue(ALU_OR, 32'h00FF_0000, 32'h0000_F00F, 5'd0, 32'h00FF_F00F, 0, 0, 0, 1, "or");
        collect();
        issue(ALU_ORI, 32'h1, 32'h8000, 5'd0, 32'h8001, 0, 0, 0, 1, "ori");
        collect();
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 0, 0, 0, 1, "slt_neg");
        collect();
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1, 0, 0, 1, "sltu_big");
        collect();
        issue(ALU_SLT, 32'h8000_0000, 32'h1, 5'd0, 32'h1, 0, 0, 0, 1, "slt_wrap");
        collect();
        issue(ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0, 1, 0, 0, 1, "slt_pos");
        collect();
        issue(ALU_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h1, 0, 0, 0, 1, "sltu_lt");
        collect();
        issue(ALU_LUI, 32'hDEAD, 32'h1234, 5'd0, 32'h1234_0000, 0, 0, 0, 1, "lui");
        collect();

        issue(ALU_SLL, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 0, 0, 0, 32, "sll31");
        collect();
        issue(ALU_SLLV, 32'h0, 32'hA, 5'd0, 32'hA, 0, 0, 0, 1, "sllv0");
        collect();
        issue(ALU_SLLV, 32'hFFFF_FFE3, 32'h5, 5'd0, 32'h28, 0, 0, 0, 4, "sllv3");
        collect();
        issue(ALU_SLL, 32'h0, 32'hF000_0001, 5'd4, 32'h10, 0, 0, 0, 5, "sll4");
        collect();
        issue(ALU_SLL, 32'h0, 32'h55, 5'd0, 32'h55, 0, 0, 0, 1, "sll0");
        collect();

        issue(ALU_ADD, 32'h1, 32'h2, 5'd0, 32'h3, 0, 0, 0, 1, "bp_add");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.out_valid_o, 1);
            chk("bp_res", bus.result_o, 32'h3);
            chk("bp_zero", bus.zero_o, 0);
            chk("bp_rdy", bus.in_ready_o, 0);
            bus.alu_ctrl_i = ALU_OR;
            bus.src1_i     = 32'hFFFF_0000;
            bus.src2_i     = 32'h0000_FFFF;
            bus.in_valid_i = 1'b1;
            @(posedge clk); #1;
            bus.in_valid_i = 1'b0;
        end
        collect();
        @(posedge clk); #1;
        chk("bp_no_capture", bus.out_valid_o, 0);

        issue(4'b1001, 32'h5, 32'h7, 5'd0, 32'h0, 1, 1, 0, 1, "ill_1001");
        collect();
        issue(4'b0000, 32'h5, 32'h7, 5'd0, 32'h0, 1, 1, 0, 1, "ill_0000");
        collect();

        issue(ALU_SLL, 32'h0, 32'h3, 5'd20, 32'h0030_0000, 0, 0, 0, 21, "abort");
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_rst_valid", bus.out_valid_o, 0);
        chk("abort_rst_rdy", bus.in_ready_o, 0);
        rst = 1'b1;
        void'(sb.pop_front());
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.out_valid_o !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", seen, 0);

        issue(ALU_ADD, 32'h2, 32'h3, 5'd0, 32'h5, 0, 0, 0, 1, "after_abort");
        collect();
        issue(ALU_SLL, 32'h0, 32'h3, 5'd2, 32'hC, 0, 0, 0, 3, "after_abort_sll");
        collect();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle ALU execution unit that consumes the 4-bit ALU control code generated by the ALU controller, together with the operands from the register file / immediate path, and produces the result and zero flag. Single-cycle operations finish in one cycle. Shifts (sll/sllv) run on an iterative one-bit-per-cycle shifter. A valid/ready handshake on both sides lets the Lab4 pipeline control stall EX while a shift is in progress.

## Interface
Parameters:
- DATA_W, 32, operand/result width (only 32 is supported)
- SHAMT_W, 5, shift-amount width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-low reset
- in_valid_i  in  1  operation request
- in_ready_o  out  1  unit can accept a request
- alu_ctrl_i  in  4  ALU control code
- src1_i  in  32  operand A (rs)
- src2_i  in  32  operand B (rt or extended immediate)
- shamt_i  in  5  instruction shamt field
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer takes result
- result_o  out  32  result
- zero_o  out  1  result == 0
- illegal_o  out  1  unrecognised control code
- overflow_o  out  1  signed overflow (add/sub; present only with ALU_EXEC_OVERFLOW_EN)

## Operation
- Codes:
  - 0001 add: A+B
  - 0010 sub: A−B
  - 0011 and
  - 0100 or
  - 0101 slt: signed A<B → 1 else 0
  - 0110 sltu: unsigned compare
  - 0111 sll: B << shamt_i
  - 1000 sllv: B << A[4:0]
  - 1011 ori: A|B
  - 1100 lui: B[15:0] << 16
  - 1111 beq: A−B; only zero_o is meaningful
- Any other code: result_o=0, zero_o=1, illegal_o=1, latency 1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, capture code and operands.
    - Non-shift, or shift with amount 0: result registered, go to DONE.
    - Shift with amount N>0: load B into the shifter, counter=N, go to SHIFT.
  - SHIFT: each cycle shift left by 1 with zero fill and decrement counter. When counter reaches 1, write the final value and go to DONE.
  - DONE: out_valid_o=1, outputs held stable. On out_ready_i go to IDLE.
- Requests are never overlapped: in_ready_o=0 in SHIFT and DONE.
- Arithmetic is modulo 2^32. slt uses the sign-corrected subtraction result, not raw bit 31.
- Operands are captured at acceptance; input changes afterwards have no effect.

## Timing
- Reset (rst_i=0 at a clock edge):
  - State becomes IDLE; all outputs are 0 while rst_i is low.
  - in_ready_o=1 from the first cycle after rst_i returns high.
  - Reset mid-SHIFT or mid-DONE aborts the operation; the pending result is discarded.
- Latency, accept edge t to out_valid_o high:
  - 1 cycle for single-cycle ops and shift amount 0
  - 1+N cycles for shift amount N
  - Maximum 32
- A new request can be accepted at the earliest one cycle after the out handshake (IDLE cycle). Throughput is one single-cycle op every 2 cycles when out_ready_i is held high.
- out_valid_o held with out_ready_i low: result_o, zero_o, illegal_o and overflow_o stay constant.
- in_valid_i while not ready: ignored, no capture.

## Configuration
- ALU_EXEC_OVERFLOW_EN defined:
  - overflow_o port exists.
  - Set for add/sub when operand signs cause a signed overflow; 0 for all other codes.
  - Registered with result_o.
- Not defined: port and logic absent; add/sub wrap silently.

## Structure
- Package alu_ctrl_pkg:
  - 4-bit localparams for every code above (ALU_ADD … ALU_BEQ)
  - FSM state encoding
  - DATA_W/SHAMT_W defaults
- Shared with the ALU controller so both ends use one code table.
- Sub-module alu_shifter: iterative left shifter with load, count, and done outputs; instantiated once.

## Test plan
- Reset: hold rst_i=0 for 2 cycles → all outputs 0. Release → in_ready_o=1, out_valid_o=0.
- add 0x7FFFFFFF+1 → out_valid_o after 1 cycle, result 0x80000000, zero 0, overflow 1 (macro on). sub 5−5 code 1111 → zero_o=1.
- slt A=0xFFFFFFFF, B=1 → 1. sltu with the same operands → 0. lui B=0x1234 → 0x12340000.
- sll B=0x1, shamt=31 → out_valid_o exactly 32 cycles after accept, result 0x80000000, in_ready_o=0 throughout. sllv A=0, B=0xA → 1 cycle, result 0xA.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE → result stable, in_valid_i pulses ignored. Release → IDLE next cycle.
- Code 1001 → illegal_o=1, result 0. Assert rst_i=0 mid-shift (cycle 10 of 20) → no out_valid_o; the next request completes correctly.
